// File: rtl/uart_tx_injector_if.sv
// uart_tx_injector_if: push/transmit bundle for the buffered UART transmitter.
interface uart_tx_injector_if #(
    parameter int G_DATA_WIDTH        = 8,
    parameter int G_BUFFER_ADDR_WIDTH = 4
) ();
    logic                           i_wr_en;
    logic [G_DATA_WIDTH-1:0]        i_wr_data;
    logic                           i_enable;
    logic                           o_tx;
    logic                           o_busy;
    logic                           o_tx_done;
    logic                           o_full;
    logic                           o_empty;
    logic [G_BUFFER_ADDR_WIDTH:0]   o_level;
    logic                           o_overflow;

    modport master (
        output i_wr_en, i_wr_data, i_enable,
        input  o_tx, o_busy, o_tx_done, o_full, o_empty, o_level, o_overflow
    );

    modport slave (
        input  i_wr_en, i_wr_data, i_enable,
        output o_tx, o_busy, o_tx_done, o_full, o_empty, o_level, o_overflow
    );
endinterface

// File: rtl/uart_tx_injector.sv
// uart_tx_injector: FIFO-buffered UART serializer emitting back-to-back frames while enabled.
module uart_tx_injector #(
    parameter int G_DATA_WIDTH        = 8,
    parameter int G_BUFFER_ADDR_WIDTH = 4,
    parameter int G_CLOCK_FREQ        = 20000000,
    parameter int G_BAUDRATE          = 115200,
    parameter int G_STOP_BIT_NUMBER   = 1,
    parameter int G_PARITY            = 0,
    parameter int G_POLARITY          = 1,
    parameter int G_FIRST_BIT         = 0
) (
    input logic clk,
    input logic rst,
    uart_tx_injector_if.slave bus
);
    localparam int C_BIT_CYCLES = G_CLOCK_FREQ / G_BAUDRATE;
    localparam int DEPTH = 2 ** G_BUFFER_ADDR_WIDTH;
    localparam int AW = G_BUFFER_ADDR_WIDTH;
    localparam int W = G_DATA_WIDTH;
    localparam int CW = $clog2(C_BIT_CYCLES);
    localparam int BW = W > 1 ? $clog2(W) : 1;
    localparam logic POL = (G_POLARITY != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t state;
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] level;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bit_idx;
    logic stop_idx;
    logic [W-1:0] sh, head;
    logic par, tx, done, overflow;
    logic full, empty, bit_end, stop_end, push, pop, cur, par_bit;

    always_comb begin
        full = level == (AW+1)'(DEPTH);
        empty = level == '0;
        bit_end = cnt == CW'(C_BIT_CYCLES - 1);
        stop_end = bit_end && stop_idx == 1'(G_STOP_BIT_NUMBER - 1);
        push = bus.i_wr_en && !full;
        pop = bus.i_enable && !empty && (state == IDLE || (state == STOP && stop_end));
        head = mem[rd_ptr];
        cur = (G_FIRST_BIT != 0) ? sh[W-1] : sh[0];
        par_bit = (G_PARITY == 2) ? ~par : par;
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= bus.i_wr_data;

    // tx is registered one state ahead so each bit appears the cycle its state begins
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
            overflow <= 1'b0;
            cnt <= '0;
            bit_idx <= '0;
            stop_idx <= 1'b0;
            sh <= '0;
            par <= 1'b0;
            tx <= POL;
            done <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
            if (bus.i_wr_en && full) overflow <= 1'b1;
            done <= 1'b0;
            cnt <= bit_end ? '0 : cnt + 1'b1;
            case (state)
                IDLE: cnt <= '0;
                START: if (bit_end) begin
                    state <= DATA;
                    bit_idx <= '0;
                    tx <= cur ~^ POL;
                    sh <= (G_FIRST_BIT != 0) ? sh << 1 : sh >> 1;
                end
                DATA: if (bit_end) begin
                    if (bit_idx == BW'(W - 1)) begin
                        state <= (G_PARITY != 0) ? PARITY : STOP;
                        tx <= (G_PARITY != 0) ? par_bit ~^ POL : POL;
                        stop_idx <= 1'b0;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                        tx <= cur ~^ POL;
                        sh <= (G_FIRST_BIT != 0) ? sh << 1 : sh >> 1;
                    end
                end
                PARITY: if (bit_end) begin
                    state <= STOP;
                    tx <= POL;
                    stop_idx <= 1'b0;
                end
                STOP: if (bit_end) begin
                    stop_idx <= stop_idx + 1'b1;
                    if (stop_end) begin
                        done <= 1'b1;
                        state <= IDLE;
                        tx <= POL;
                    end
                end
                default: state <= IDLE;
            endcase
            if (pop) begin
                state <= START;
                sh <= head;
                par <= ^head;
                tx <= ~POL;
                cnt <= '0;
            end
        end
    end

    assign bus.o_tx = tx;
    assign bus.o_busy = state != IDLE;
    assign bus.o_tx_done = done;
    assign bus.o_full = full;
    assign bus.o_empty = empty;
    assign bus.o_level = level;
    assign bus.o_overflow = overflow;
endmodule

// File: tb/tb_uart_tx_injector.sv
// tb_uart_tx_injector: four parameter variants driven with random traffic, checked against a frame-level model.
module tb_uart_tx_injector;
    localparam int PAR_T [4] = '{0, 1, 2, 0};
    localparam int STOP_T [4] = '{1, 1, 2, 2};
    localparam int POL_T [4] = '{1, 0, 1, 0};
    localparam int FIRST_T [4] = '{0, 1, 0, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] wr_en = '0;
    logic [3:0] en = '0;
    logic [7:0] wr_data [4];
    logic [3:0] tx, busy, done, full, empty, ovf;
    logic [4:0] level [4];
    logic [7:0] exp_q [4][$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [11:0] frame(logic [7:0] b, int par, int stopn, int pol, int first);
        logic [11:0] f = '0;
        int n = 9;
        for (int i = 0; i < 8; i++) f[1+i] = (first != 0) ? b[7-i] : b[i];
        if (par != 0) begin
            f[n] = ($countones(b) % 2 == 1) ^ (par == 2);
            n++;
        end
        for (int s = 0; s < stopn; s++) f[n+s] = 1'b1;
        n += stopn;
        if (pol == 0) f ^= 12'((1 << n) - 1);
        return f;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : u
        localparam int FL = 1 + 8 + (PAR_T[g] != 0) + STOP_T[g];
        localparam logic PL = (POL_T[g] != 0);
        uart_tx_injector_if #(.G_DATA_WIDTH(8), .G_BUFFER_ADDR_WIDTH(4)) bus ();
        assign bus.i_wr_en = wr_en[g];
        assign bus.i_wr_data = wr_data[g];
        assign bus.i_enable = en[g];
        assign tx[g] = bus.o_tx;
        assign busy[g] = bus.o_busy;
        assign done[g] = bus.o_tx_done;
        assign full[g] = bus.o_full;
        assign empty[g] = bus.o_empty;
        assign level[g] = bus.o_level;
        assign ovf[g] = bus.o_overflow;
        uart_tx_injector #(
            .G_DATA_WIDTH(8), .G_BUFFER_ADDR_WIDTH(4), .G_CLOCK_FREQ(1000000), .G_BAUDRATE(100000),
            .G_STOP_BIT_NUMBER(STOP_T[g]), .G_PARITY(PAR_T[g]), .G_POLARITY(POL_T[g]), .G_FIRST_BIT(FIRST_T[g])
        ) dut (.clk(clk), .rst(rst), .bus(bus));

        // line monitor: every frame must hold each bit 10 cycles and match the next queued byte
        initial begin : mon
            logic [11:0] got, want;
            logic cur_l;
            logic [7:0] b;
            bit ok, pend, abort;
            pend = 0;
            forever begin
                if (!pend) @(negedge clk);
                pend = 0;
                if (!rst && tx[g] !== PL) begin
                    if (exp_q[g].size() == 0) begin
                        check($sformatf("spurious%0d", g), 1, 0);
                        b = '0;
                    end else b = exp_q[g].pop_front();
                    want = frame(b, PAR_T[g], STOP_T[g], POL_T[g], FIRST_T[g]);
                    got = '0;
                    ok = 1;
                    abort = 0;
                    cur_l = tx[g];
                    for (int k = 0; k < FL * 10; k++) begin
                        if (k > 0) @(negedge clk);
                        if (rst) begin
                            abort = 1;
                            break;
                        end
                        if (k % 10 == 0) cur_l = tx[g];
                        if (k % 10 == 5) got[k/10] = tx[g];
                        ok = ok && tx[g] === cur_l && busy[g] === 1'b1 && (k == 0 || done[g] === 1'b0);
                    end
                    if (!abort) begin
                        check($sformatf("frame%0d", g), 32'(got), 32'(want));
                        check($sformatf("timing%0d", g), 32'(ok), 1);
                        @(negedge clk);
                        if (!rst) check($sformatf("done%0d", g), 32'(done[g]), 1);
                        pend = 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        for (int i = 0; i < 4; i++)
            if (wr_en[i] && exp_q[i].size() < 16) exp_q[i].push_back(wr_data[i]);
        tick();
        wr_en = '0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        bit quiet = 0;
        while (n < budget && !quiet) begin
            tick();
            n++;
            quiet = busy == '0;
            for (int i = 0; i < 4; i++) quiet = quiet && exp_q[i].size() == 0 && level[i] == '0;
        end
        check("drain", 32'(quiet), 1);
    endtask

    initial begin
        int n, nd, w;
        for (int i = 0; i < 4; i++) wr_data[i] = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_tx%0d", i), 32'(tx[i]), 32'(POL_T[i]));
            check($sformatf("rst_flags%0d", i), {busy[i], done[i], full[i], empty[i], ovf[i]}, 5'b00010);
            check($sformatf("rst_level%0d", i), 32'(level[i]), 0);
        end

        tick();
        en[0] = 1'b1;
        wr_en[0] = 1'b1;
        wr_data[0] = 8'hA5;
        step();
        @(negedge clk);
        check("lat_level", 32'(level[0]), 1);
        check("lat_idle", 32'(tx[0]), 1);
        @(negedge clk);
        check("lat_start", 32'(tx[0]), 0);
        drain(400);

        en = '1;
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < 4; i++) begin
                wr_en[i] = ($urandom_range(0, 9) == 0) && exp_q[i].size() < 15;
                wr_data[i] = 8'($urandom);
            end
            step();
        end
        drain(8000);

        en = '0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 16; k++) begin
                wr_en[i] = 1'b1;
                wr_data[i] = 8'($urandom);
                step();
            end
            @(negedge clk);
            check($sformatf("full%0d", i), {full[i], empty[i], ovf[i]}, 3'b100);
            check($sformatf("level16_%0d", i), 32'(level[i]), 16);
            wr_en[i] = 1'b1;
            wr_data[i] = 8'hEE;
            step();
            @(negedge clk);
            check($sformatf("overflow%0d", i), 32'(ovf[i]), 1);
            check($sformatf("level_drop%0d", i), 32'(level[i]), 16);
            tick();
            en[i] = 1'b1;
            w = 0;
            while (!busy[i] && w < 10) begin
                @(negedge clk);
                w++;
            end
            n = 0;
            nd = 0;
            while (busy[i] && n < 4000) begin
                n++;
                nd += 32'(done[i]);
                @(negedge clk);
            end
            nd += 32'(done[i]);
            check($sformatf("busy_run%0d", i), n, 16 * 10 * (9 + (PAR_T[i] != 0) + STOP_T[i]));
            check($sformatf("done_cnt%0d", i), nd, 16);
            check($sformatf("empty%0d", i), 32'(empty[i]), 1);
        end

        tick();
        en[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wr_en[1] = 1'b1;
            wr_data[1] = 8'($urandom);
            step();
        end
        en[1] = 1'b1;
        w = 0;
        while (!busy[1] && w < 10) begin
            tick();
            w++;
        end
        repeat (20) tick();
        en[1] = 1'b0;
        w = 0;
        while (busy[1] && w < 200) begin
            tick();
            w++;
        end
        repeat (50) tick();
        check("hold_level", 32'(level[1]), 1);
        check("hold_line", {busy[1], tx[1]}, 2'b00);
        en[1] = 1'b1;
        drain(400);

        for (int k = 0; k < 3; k++) begin
            wr_en[0] = 1'b1;
            wr_data[0] = 8'($urandom);
            step();
        end
        repeat (30) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("mid_rst_tx", 32'(tx[0]), 1);
        check("mid_rst_level", 32'(level[0]), 0);
        check("mid_rst_busy", 32'(busy[0]), 0);
        check("mid_rst_ovf", 32'(ovf), 0);
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        tick();
        rst = 1'b0;

        for (int b = 0; b < 40; b++) begin
            w = 0;
            while (w < 2000 && (exp_q[0].size() >= 15 || exp_q[1].size() >= 15 || exp_q[2].size() >= 15 || exp_q[3].size() >= 15)) begin
                tick();
                w++;
            end
            for (int i = 0; i < 4; i++) begin
                wr_en[i] = 1'b1;
                wr_data[i] = 8'(b);
            end
            step();
        end
        drain(8000);

        for (int i = 0; i < 4; i++) check($sformatf("leftover%0d", i), exp_q[i].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end
endmodule

// File: doc/uart_tx_injector.md
Name: uart_tx_injector

Overview:
- Buffered UART transmitter for the UART testbench library.
- The testbench pushes bytes into an internal FIFO. The block serializes them onto a UART line using back-to-back frames while enabled.
- It is the transmit-side counterpart of the buffered RX storage used by the UART checker.
- The serializer is self-contained, with no external tx_uart instance, so bit-level timing is fully specified here.

Parameters:
G_DATA_WIDTH, 8, data bits per frame
G_BUFFER_ADDR_WIDTH, 4, FIFO depth = 2**G_BUFFER_ADDR_WIDTH
G_CLOCK_FREQ, 20000000, clk frequency in Hz
G_BAUDRATE, 115200, line rate; C_BIT_CYCLES = G_CLOCK_FREQ / G_BAUDRATE (integer division, must be >= 2)
G_STOP_BIT_NUMBER, 1, stop bits (1 or 2)
G_PARITY, 0, 0 none / 1 even / 2 odd
G_POLARITY, 1, idle line level; 0 inverts every transmitted bit
G_FIRST_BIT, 0, 0 LSB first / 1 MSB first

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
i_wr_en  in  1  push i_wr_data into FIFO
i_wr_data  in  G_DATA_WIDTH  byte to transmit
i_enable  in  1  allow new frames to start
o_tx  out  1  UART serial line
o_busy  out  1  frame in progress
o_tx_done  out  1  one-cycle pulse per completed frame
o_full  out  1  FIFO full
o_empty  out  1  FIFO empty
o_level  out  G_BUFFER_ADDR_WIDTH+1  FIFO occupancy
o_overflow  out  1  sticky: write attempted while full

Behaviour:
- Reset values:
  - o_tx = G_POLARITY; o_busy = 0; o_tx_done = 0.
  - o_full = 0; o_empty = 1; o_level = 0; o_overflow = 0.
  - FIFO pointers = 0; FSM = IDLE.
- Reset mid-frame: the frame is aborted, o_tx returns to idle level on the next edge, and the FIFO is flushed.
- FIFO:
  - Write in cycle n is reflected in o_level/o_empty at n+1.
  - Write while o_full=1 is dropped and sets o_overflow, even if a pop occurs the same cycle.
  - Simultaneous write and pop when not full: level unchanged, write accepted.
  - Pointers wrap modulo depth; level counts 0..depth.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if i_enable=1 and o_empty=0, pop the head into the shift register and go to START. Otherwise stay.
  - START: o_tx = ~G_POLARITY for C_BIT_CYCLES, then DATA.
  - DATA: G_DATA_WIDTH bits, C_BIT_CYCLES each, in the order given by G_FIRST_BIT; then PARITY if G_PARITY!=0, else STOP.
  - PARITY: even parity bit = XOR of data bits; odd parity bit = its inverse. Lasts C_BIT_CYCLES.
  - STOP: level G_POLARITY for G_STOP_BIT_NUMBER*C_BIT_CYCLES.
  - STOP exit:
    - At the last cycle of STOP, if i_enable=1 and the FIFO is non-empty, pop and go directly to START (zero inter-frame gap).
    - Else go to IDLE.
- Line encoding: each data and parity bit is driven as bit XNOR G_POLARITY (inverted when G_POLARITY=0). Start and stop bits are as above.
- Bit timing:
  - A single cycle counter counts 0..C_BIT_CYCLES-1 and advances the bit index at terminal count.
  - The bit counter is sized for G_DATA_WIDTH.
- Latency:
  - Pop in cycle n; the start bit appears on o_tx from cycle n+1.
  - Write into an empty FIFO with enable high: start bit appears 2 cycles after the write cycle.
- Frame length: (1 + G_DATA_WIDTH + (G_PARITY!=0) + G_STOP_BIT_NUMBER) * C_BIT_CYCLES cycles.
- o_busy = 1 in every non-IDLE state, including continuous high across back-to-back frames.
- o_tx_done: registered pulse in the first cycle after the final stop-bit cycle of each frame.
- i_enable deasserted mid-frame: the current frame completes normally; no new pop occurs until i_enable=1.

Test Plan:
All tests use G_CLOCK_FREQ=1000000, G_BAUDRATE=100000 (10 cycles/bit), depth 16.
- 0xA5, no parity, 1 stop, LSB first, enable=1:
  - o_tx sequence 0,1,0,1,0,0,1,0,1,1 with 10 cycles each.
  - Start bit begins 2 cycles after the write.
  - o_tx_done pulses exactly 100 cycles after the start edge.
- Parity:
  - G_PARITY=1 with 0x07 -> parity bit 1; with 0x03 -> 0.
  - G_PARITY=2 with 0x07 -> parity bit 0.
  - Frame length is 110 cycles.
- Full/overflow/back-to-back:
  - With enable=0, write 16 bytes -> o_full=1, o_level=16.
  - A 17th write is dropped and o_overflow=1.
  - Raise enable -> 16 frames with no gaps, o_busy high for 1600 cycles, o_empty=1 after the final pop, 16 o_tx_done pulses.
- Bit order and polarity:
  - G_FIRST_BIT=1 with 0x80 -> first data bit 1 followed by seven 0s.
  - G_POLARITY=0: idle line 0, start bit 1, and all data bits inverted relative to the G_POLARITY=1 capture.
- Enable drop and reset:
  - Drop enable mid-frame with 2 bytes queued -> the frame finishes, the line idles, and o_level=1 holds.
  - Assert rst mid-frame -> o_tx=G_POLARITY next cycle, o_level=0, o_overflow=0, o_busy=0.
- Two stop bits and wrap:
  - G_STOP_BIT_NUMBER=2 -> 110-cycle frame without parity.
  - Write and transmit 40 bytes in sequence 0x00..0x27 -> received order is identical across the pointer wrap.
